// File: rtl/stb_meas_pkg.sv
// Shared types and constants for the strobe-generator measurement sequencer.
package stb_meas_pkg;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_GEN_RST  = 6'b000010,
        S_WAIT_RDY = 6'b000100,
        S_SAMPLE   = 6'b001000,
        S_CHECK    = 6'b010000,
        S_RESULT   = 6'b100000
    } state_e;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_UNSTABLE = 2'd2;
    localparam logic [1:0] ST_ABORT    = 2'd3;

    // Up to 128 runs: the run counter needs 8 bits and the sum 7 extra bits.
    localparam int RUN_W       = 8;
    localparam int SUM_EXTRA_W = 7;

endpackage

// File: rtl/period_stats.sv
// Running min/max/sum of captured generator periods; one update per accumulate pulse.
module period_stats
    import stb_meas_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          clear_i,
    input  logic                          acc_i,
    input  logic [W-1:0]                  sample_i,
    output logic [W-1:0]                  min_o,
    output logic [W-1:0]                  max_o,
    output logic [int'(W)+SUM_EXTRA_W-1:0] sum_o
);

    localparam int SUM_W = int'(W) + SUM_EXTRA_W;

    logic [W-1:0]     min_q;
    logic [W-1:0]     max_q;
    logic [SUM_W-1:0] sum_q;

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking so every register sees pre-edge values; blocking would chain updates within one edge.
        if (!arst_i) begin
            min_q <= '1;
            max_q <= '0;
            sum_q <= '0;
        end else if (clear_i) begin
            min_q <= '1;
            max_q <= '0;
            sum_q <= '0;
        end else if (acc_i) begin
            if (sample_i < min_q) min_q <= sample_i;
            if (sample_i > max_q) max_q <= sample_i;
            sum_q <= sum_q + SUM_W'(sample_i);
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/stb_meas_ctrl.sv
// Measurement sequencer: resets/releases the strobe generator 2^n times, collects
// period statistics and hands one result record to the register block.
module stb_meas_ctrl
    import stb_meas_pkg::*;
#(
    parameter int unsigned T_CNT_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 2**24,
    parameter int unsigned RST_CYCLES     = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [2:0]             n_log2_i,
    input  logic [15:0]            tol_i,
    output logic                   busy_o,
    output logic                   gen_rst_n_o,
    output logic                   gen_oe_o,
    input  logic                   gen_rdy_i,
    input  logic                   gen_err_i,
    input  logic [T_CNT_WIDTH-1:0] gen_period_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [1:0]             res_status_o,
    output logic [T_CNT_WIDTH-1:0] res_mean_o,
    output logic [T_CNT_WIDTH-1:0] res_min_o,
    output logic [T_CNT_WIDTH-1:0] res_max_o
);

    localparam int W     = int'(T_CNT_WIDTH);
    localparam int SUM_W = W + SUM_EXTRA_W;
    localparam int RC_W  = $clog2(RST_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [2:0]       n_q;
    logic [15:0]      tol_q;
    logic [RUN_W-1:0] run_q;
    logic [RC_W-1:0]  rst_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [W-1:0]     period_q;
    logic [1:0]       res_status_q;
    logic [W-1:0]     res_mean_q, res_min_q, res_max_q;

    logic             stats_clr, stats_acc, load_res;
    logic [1:0]       status_d;
    logic [W-1:0]     mean_d;
    logic [W-1:0]     st_min, st_max;
    logic [SUM_W-1:0] st_sum;

    period_stats #(.W(T_CNT_WIDTH)) u_stats (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .clear_i  (stats_clr),
        .acc_i    (stats_acc),
        .sample_i (period_q),
        .min_o    (st_min),
        .max_o    (st_max),
        .sum_o    (st_sum)
    );

    logic rst_done, to_done, run_last, unstable, in_run;
    assign rst_done = (rst_cnt_q == RC_W'(RST_CYCLES - 1));
    assign to_done  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign run_last = (run_q == ((RUN_W'(1) << n_q) - RUN_W'(1)));
    assign unstable = ((st_max - st_min) > W'(tol_q));
    assign in_run   = (state_q == S_GEN_RST) || (state_q == S_WAIT_RDY) ||
                      (state_q == S_SAMPLE)  || (state_q == S_CHECK);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_d   = state_q;
        stats_clr = 1'b0;
        stats_acc = 1'b0;
        load_res  = 1'b0;
        status_d  = ST_ABORT;
        mean_d    = '0;

        if (abort_i && in_run) begin
            state_d  = S_RESULT;
            load_res = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d   = S_GEN_RST;
                        stats_clr = 1'b1;
                    end
                end
                S_GEN_RST: begin
                    if (rst_done) state_d = S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (gen_rdy_i) begin
                        state_d = S_SAMPLE;
                    end else if (gen_err_i) begin
                        state_d  = S_RESULT;
                        load_res = 1'b1;
                    end else if (to_done) begin
                        state_d  = S_RESULT;
                        load_res = 1'b1;
                        status_d = ST_TIMEOUT;
                    end
                end
                S_SAMPLE: begin
                    stats_acc = 1'b1;
                    state_d   = run_last ? S_CHECK : S_GEN_RST;
                end
                S_CHECK: begin
                    state_d  = S_RESULT;
                    load_res = 1'b1;
                    status_d = unstable ? ST_UNSTABLE : ST_OK;
                    mean_d   = W'(st_sum >> n_q);
                end
                S_RESULT: begin
                    if (res_ready_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            tol_q        <= '0;
            run_q        <= '0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            period_q     <= '0;
            res_status_q <= ST_OK;
            res_mean_q   <= '0;
            res_min_q    <= '0;
            res_max_q    <= '0;
        end else begin
            state_q <= state_d;
            if (stats_clr) begin
                n_q   <= n_log2_i;
                tol_q <= tol_i;
                run_q <= '0;
            end else if (stats_acc) begin
                run_q <= run_q + RUN_W'(1);
            end
            // Both counters idle at zero so each state entry starts a fresh count.
            rst_cnt_q <= (state_q == S_GEN_RST)  ? rst_cnt_q + RC_W'(1) : '0;
            to_cnt_q  <= (state_q == S_WAIT_RDY) ? to_cnt_q + TO_W'(1)  : '0;
            if ((state_q == S_WAIT_RDY) && gen_rdy_i) period_q <= gen_period_i;
            if (load_res) begin
                res_status_q <= status_d;
                res_mean_q   <= mean_d;
                res_min_q    <= st_min;
                res_max_q    <= st_max;
            end
        end
    end

    logic gen_on;
    assign gen_on       = (state_q != S_IDLE) && (state_q != S_GEN_RST);
    assign busy_o       = (state_q != S_IDLE);
    assign gen_rst_n_o  = gen_on;
    assign gen_oe_o     = gen_on;
    assign res_valid_o  = (state_q == S_RESULT);
    assign res_status_o = res_status_q;
    assign res_mean_o   = res_mean_q;
    assign res_min_o    = res_min_q;
    assign res_max_o    = res_max_q;

endmodule

// File: tb/tb_stb_meas_ctrl.sv
// Self-checking bench for stb_meas_ctrl with a behavioural strobe-generator model
// and a scoreboard of expected result records.
module tb_stb_meas_ctrl;
    import stb_meas_pkg::*;

    localparam int W  = 32;
    localparam int TO = 64;
    localparam int RC = 4;

    logic         clk = 1'b0;
    logic         arst = 1'b0;
    logic         start = 1'b0, abort = 1'b0;
    logic [2:0]   n_log2 = '0;
    logic [15:0]  tol_v = '0;
    logic         busy, gen_rst_n, gen_oe;
    logic         gen_rdy = 1'b0, gen_err = 1'b0;
    logic [W-1:0] gen_period = '0;
    logic         res_valid, res_ready = 1'b0;
    logic [1:0]   res_status;
    logic [W-1:0] res_mean, res_min, res_max;

    always #5 clk = ~clk;

    stb_meas_ctrl #(.T_CNT_WIDTH(W), .TIMEOUT_CYCLES(TO), .RST_CYCLES(RC)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .start_i      (start),
        .abort_i      (abort),
        .n_log2_i     (n_log2),
        .tol_i        (tol_v),
        .busy_o       (busy),
        .gen_rst_n_o  (gen_rst_n),
        .gen_oe_o     (gen_oe),
        .gen_rdy_i    (gen_rdy),
        .gen_err_i    (gen_err),
        .gen_period_i (gen_period),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_status_o (res_status),
        .res_mean_o   (res_mean),
        .res_min_o    (res_min),
        .res_max_o    (res_max)
    );

    typedef struct {
        logic [1:0]   status;
        logic [W-1:0] mean;
        logic [W-1:0] min;
        logic [W-1:0] max;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Generator model: after each release, ready (or error) rises gen_lat cycles later.
    int           gen_lat = 3;
    bit           gen_never_rdy = 1'b0;
    bit           gen_err_en = 1'b0;
    logic [W-1:0] per_tab [4];
    int           gen_base = 0;
    int           rel_cnt = 0;
    int           wait_cnt = 0;
    bit           prev_rel = 1'b0;

    always @(negedge clk) begin
        if (!gen_rst_n) begin
            gen_rdy  = 1'b0;
            gen_err  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (!prev_rel) rel_cnt++;
            wait_cnt++;
            if (wait_cnt == gen_lat) begin
                if (gen_err_en) begin
                    gen_err = 1'b1;
                end else if (!gen_never_rdy) begin
                    gen_rdy    = 1'b1;
                    gen_period = per_tab[(rel_cnt - gen_base - 1) % 4];
                end
            end
        end
        prev_rel = gen_rst_n;
    end

    task automatic set_pers(input logic [W-1:0] p0, p1, p2, p3);
        per_tab[0] = p0; per_tab[1] = p1; per_tab[2] = p2; per_tab[3] = p3;
        gen_base   = rel_cnt;
    endtask

    task automatic push_exp(input logic [1:0] s, input logic [W-1:0] mean, mn, mx);
        res_t r;
        r.status = s; r.mean = mean; r.min = mn; r.max = mx;
        exp_q.push_back(r);
    endtask

    task automatic start_run(input logic [2:0] n, input logic [15:0] t);
        @(negedge clk);
        n_log2 = n; tol_v = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        while (!res_valid && edges < budget) begin
            @(posedge clk); #1;
            edges++;
        end
        check("valid_seen", res_valid, 1);
    endtask

    // Scoreboard pop: compare the presented record, then complete the handshake.
    task automatic take_result(input bit start_in_xfer);
        res_t e;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_status", res_status, e.status);
            check("res_mean", res_mean, e.mean);
            check("res_min", res_min, e.min);
            check("res_max", res_max, e.max);
        end
        @(negedge clk);
        res_ready = 1'b1;
        start     = start_in_xfer;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("busy_after_xfer", busy, 0);
        check("valid_after_xfer", res_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int edges;
        int cnt;
        bit saw_valid;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_gen_rst_n", gen_rst_n, 0);
        check("rst_gen_oe", gen_oe, 0);
        check("rst_valid", res_valid, 0);
        check("rst_status", res_status, 0);
        check("rst_mean", res_mean, 0);
        check("rst_min", res_min, 0);
        check("rst_max", res_max, 0);
        @(negedge clk);
        arst = 1'b1;

        // Nominal: four runs of period 100 with the reset/release timing checked.
        set_pers(100, 100, 100, 100);
        push_exp(ST_OK, 100, 100, 100);
        start_run(3'd2, 16'd0);
        check("busy_on_start", busy, 1);
        check("gen_rst_held", gen_rst_n, 0);
        repeat (RC - 1) @(posedge clk);
        #1;
        check("gen_rst_last_cycle", gen_rst_n, 0);
        @(posedge clk); #1;
        check("gen_released", gen_rst_n, 1);
        check("gen_oe_on", gen_oe, 1);
        wait_valid(500, edges);
        check("release_count", rel_cnt - gen_base, 4);
        // Hold ready low: the record must stay presented.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
        end
        take_result(1'b0);

        // Spread 4: unstable with tol 3, OK with tol 4.
        set_pers(98, 100, 102, 100);
        push_exp(ST_UNSTABLE, 100, 98, 102);
        start_run(3'd2, 16'd3);
        wait_valid(500, edges);
        take_result(1'b0);
        set_pers(98, 100, 102, 100);
        push_exp(ST_OK, 100, 98, 102);
        start_run(3'd2, 16'd4);
        wait_valid(500, edges);
        take_result(1'b0);

        // 128 runs: 32 each of 1000..1003, mean 1001.5 truncates to 1001.
        set_pers(1000, 1001, 1002, 1003);
        push_exp(ST_OK, 1001, 1000, 1003);
        start_run(3'd7, 16'd3);
        wait_valid(5000, edges);
        take_result(1'b0);

        // Timeout with no ready at all.
        gen_never_rdy = 1'b1;
        set_pers(5, 5, 5, 5);
        push_exp(ST_TIMEOUT, 0, 32'hFFFF_FFFF, 0);
        start_run(3'd2, 16'd0);
        wait_valid(200, edges);
        check("timeout_latency", edges + 1, 1 + RC + TO);
        take_result(1'b0);
        gen_never_rdy = 1'b0;

        // Ready on the last counted cycle beats the timeout.
        gen_lat = TO;
        set_pers(77, 77, 77, 77);
        push_exp(ST_OK, 77, 77, 77);
        start_run(3'd0, 16'd0);
        wait_valid(200, edges);
        check("rdy_last_cycle_latency", edges + 1, 1 + RC + TO + 2);
        take_result(1'b0);
        gen_lat = 3;

        // Abort during run 2 of 4.
        set_pers(50, 50, 50, 50);
        push_exp(ST_ABORT, 0, 50, 50);
        start_run(3'd2, 16'd0);
        cnt = 0;
        while ((rel_cnt - gen_base) < 2 && cnt < 200) begin
            @(negedge clk); #1;
            cnt++;
        end
        check("abort_in_run2", rel_cnt - gen_base, 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_next_cycle", res_valid, 1);
        take_result(1'b0);

        // Generator error while waiting for ready.
        gen_err_en = 1'b1;
        push_exp(ST_ABORT, 0, 32'hFFFF_FFFF, 0);
        start_run(3'd1, 16'd0);
        wait_valid(200, edges);
        take_result(1'b0);
        gen_err_en = 1'b0;

        // Start during the transfer edge is ignored; start on the next edge is accepted.
        set_pers(100, 100, 100, 100);
        push_exp(ST_OK, 100, 100, 100);
        start_run(3'd0, 16'd0);
        wait_valid(200, edges);
        n_log2 = 3'd0; tol_v = 16'd0;
        push_exp(ST_OK, 100, 100, 100);
        take_result(1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_xfer_accepted", busy, 1);
        wait_valid(200, edges);
        take_result(1'b0);

        // Start together with abort in IDLE: nothing happens.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);

        // Reset in WAIT_RDY discards the run.
        gen_never_rdy = 1'b1;
        start_run(3'd1, 16'd0);
        cnt = 0;
        while (!gen_rst_n && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("reached_wait_rdy", gen_rst_n, 1);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk); #1;
        arst = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gen_rst_n", gen_rst_n, 0);
        check("mid_rst_gen_oe", gen_oe, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_status", res_status, 0);
        check("mid_rst_mean", res_mean, 0);
        check("mid_rst_min", res_min, 0);
        check("mid_rst_max", res_max, 0);
        saw_valid = 1'b0;
        repeat (150) begin
            @(posedge clk); #1;
            if (res_valid) saw_valid = 1'b1;
        end
        check("no_valid_after_rst", saw_valid, 0);
        gen_never_rdy = 1'b0;

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
